comp_load_driver: RTL

//  Initiator side of the comparator operand-load interface: takes two 8-bit operands on a start request,

---
 rtl/comp_load_driver_pkg.sv | 22 ++
 rtl/comp_load_driver_if.sv | 36 +++
 rtl/comp_load_driver.sv | 128 ++++++++++++
 3 files changed

// File: rtl/comp_load_driver_pkg.sv
// comp_load_driver_pkg: FSM state encodings, nibble-index constants and result helper for comp_load_driver
package comp_load_driver_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_GAP,
        S_WAIT,
        S_CAPTURE
    } state_t;

    localparam logic [1:0] NIB_AL = 2'd0;
    localparam logic [1:0] NIB_AH = 2'd1;
    localparam logic [1:0] NIB_BL = 2'd2;
    localparam logic [1:0] NIB_BH = 2'd3;

    function automatic logic not_onehot3(input logic [2:0] v);
        return !(v == 3'b100 || v == 3'b010 || v == 3'b001);
    endfunction

endpackage

// File: rtl/comp_load_driver_if.sv
// comp_load_driver_if: host request/result and comparator nibble/strobe bus of the operand-load driver
//   start,a,b        host request and operands
//   busy,done        run in progress / one-cycle completion pulse
//   pb1..pb4,q       load strobes and nibble bus toward the comparator
//   lo,eo,go         comparator result (A<B, A==B, A>B)
//   lt,eq,gt,err     captured result and not-one-hot flag
//   master = driver side, slave = host plus comparator side
interface comp_load_driver_if;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic       pb1;
    logic       pb2;
    logic       pb3;
    logic       pb4;
    logic [3:0] q;
    logic       lo;
    logic       eo;
    logic       go;
    logic       lt;
    logic       eq;
    logic       gt;
    logic       err;

    modport master (
        input  start, a, b, lo, eo, go,
        output busy, done, pb1, pb2, pb3, pb4, q, lt, eq, gt, err
    );

    modport slave (
        output start, a, b, lo, eo, go,
        input  busy, done, pb1, pb2, pb3, pb4, q, lt, eq, gt, err
    );
endinterface

// File: rtl/comp_load_driver.sv
// comp_load_driver: replays two latched 8-bit operands to the comparator as four nibble/strobe loads, then captures its result
//   i_clk    rising-edge clock
//   i_rst_n  synchronous active-low reset
//   io_bus   comp_load_driver_if.master (request, strobes, nibble bus, result)
module comp_load_driver
    import comp_load_driver_pkg::*;
#(
    parameter int SETUP_CYC = 1,
    parameter int HOLD_CYC  = 2,
    parameter int RESP_WAIT = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    comp_load_driver_if.master    io_bus
);
    localparam int MAX_SH = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
    localparam int MAXC   = (MAX_SH > RESP_WAIT) ? MAX_SH : RESP_WAIT;
    localparam int CW     = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] WAIT_LD  = CW'(RESP_WAIT - 1);
    localparam logic [CW-1:0] ONE      = CW'(1);

    state_t        r_state;
    logic [1:0]    r_k;
    logic [CW-1:0] r_cnt;
    logic [7:0]    r_a;
    logic [7:0]    r_b;
    logic [3:0]    r_pb;
    logic [3:0]    r_q;
    logic          r_busy;
    logic          r_done;
    logic          r_lt;
    logic          r_eq;
    logic          r_gt;
    logic          r_err;
    logic [1:0]    w_k_nxt;
    logic [3:0]    w_nib;

    // q for the next nibble is loaded on the GAP->SETUP edge, so it is stable for the whole SETUP phase
    always_comb begin
        w_k_nxt = r_k + 2'd1;
        w_nib   = (w_k_nxt == NIB_AL) ? r_a[3:0] :
                  (w_k_nxt == NIB_AH) ? r_a[7:4] :
                  (w_k_nxt == NIB_BL) ? r_b[3:0] : r_b[7:4];
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_k     <= NIB_AL;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_pb    <= '0;
            r_q     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_lt    <= 1'b0;
            r_eq    <= 1'b0;
            r_gt    <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: if (io_bus.start) begin
                    r_a     <= io_bus.a;
                    r_b     <= io_bus.b;
                    r_k     <= NIB_AL;
                    r_q     <= io_bus.a[3:0];
                    r_cnt   <= SETUP_LD;
                    r_busy  <= 1'b1;
                    r_state <= S_SETUP;
                end
                S_SETUP: if (r_cnt == '0) begin
                    r_pb    <= 4'b0001 << r_k;
                    r_cnt   <= HOLD_LD;
                    r_state <= S_STROBE;
                end else begin
                    r_cnt <= r_cnt - ONE;
                end
                S_STROBE: if (r_cnt == '0) begin
                    r_pb    <= '0;
                    r_state <= S_GAP;
                end else begin
                    r_cnt <= r_cnt - ONE;
                end
                S_GAP: if (r_k == NIB_BH) begin
                    r_cnt   <= WAIT_LD;
                    r_state <= S_WAIT;
                end else begin
                    r_k     <= w_k_nxt;
                    r_q     <= w_nib;
                    r_cnt   <= SETUP_LD;
                    r_state <= S_SETUP;
                end
                // result is sampled on the edge into CAPTURE so it is valid alongside done
                S_WAIT: if (r_cnt == '0) begin
                    r_lt    <= io_bus.lo;
                    r_eq    <= io_bus.eo;
                    r_gt    <= io_bus.go;
                    r_err   <= not_onehot3({io_bus.lo, io_bus.eo, io_bus.go});
                    r_done  <= 1'b1;
                    r_state <= S_CAPTURE;
                end else begin
                    r_cnt <= r_cnt - ONE;
                end
                S_CAPTURE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign io_bus.busy = r_busy;
    assign io_bus.done = r_done;
    assign io_bus.pb1  = r_pb[0];
    assign io_bus.pb2  = r_pb[1];
    assign io_bus.pb3  = r_pb[2];
    assign io_bus.pb4  = r_pb[3];
    assign io_bus.q    = r_q;
    assign io_bus.lt   = r_lt;
    assign io_bus.eq   = r_eq;
    assign io_bus.gt   = r_gt;
    assign io_bus.err  = r_err;
endmodule
